aurora_tx_sched: RTL and testbench
==================================

Name: aurora_tx_sched

Overview:
Round-robin scheduler that shares one Aurora TX AXI-stream lane among N_CH decimated acquisition channels. Each channel's encoder/decimator output is buffered in a first-word-fall-through FIFO. The scheduler grants one channel at a time and emits a fixed-length packet: one header word, then BURST_LEN payload words, with tlast on the final word. It also issues the cfg_rst pulse that realigns the upstream decimator phase counters when acquisition is enabled.

Parameters:
DATA_WD, 64, word width; must be >= 64.
N_CH, 4, number of requesting channels (2..16).
CH_WD, 2, channel index width; equals clog2(N_CH).
BURST_LEN, 16, payload words per packet (2..255).

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
i_enable  input  1  acquisition enable level
i_ch_rdy  input  N_CH  bit k high: FIFO k holds >= BURST_LEN words
i_ch_data  input  N_CH*DATA_WD  FWFT head word of each FIFO; channel k at bits [k*DATA_WD +: DATA_WD]
o_ch_rd  output  N_CH  one-hot FIFO read strobe
m_axis_tvalid  output  1  TX stream valid
m_axis_tready  input  1  TX stream ready
m_axis_tdata  output  DATA_WD  TX stream data
m_axis_tlast  output  1  last word of packet
o_cfg_rst  output  1  one-cycle realign pulse to upstream decimators
o_busy  output  1  packet in progress
o_pkt_cnt  output  32  total packets completed since reset

Behaviour:
- Reset (rst=1 at a clk edge) applies to all registers, including mid-packet:
  - state=IDLE; outputs m_axis_tvalid, m_axis_tlast, o_ch_rd, o_cfg_rst, o_busy = 0; o_pkt_cnt=0.
  - Per-channel 16-bit seq counters = 0; last_grant = N_CH-1, so the first grant searches from channel 0.
  - The partially sent packet is abandoned; no tlast is emitted for it.
- Enable edge:
  - en_d registers i_enable.
  - o_cfg_rst=1 for exactly the one cycle after a 0->1 transition of i_enable.
  - ARB is not entered in the cycle o_cfg_rst is high.
- States:
  - IDLE: go to ARB when en_d=1 and o_cfg_rst=0.
  - ARB (1 cycle):
    - Search i_ch_rdy round-robin, starting at (last_grant+1) mod N_CH.
    - On a hit: latch sel, set last_grant=sel, go to HDR.
    - No requester: stay in ARB. If en_d=0, go to IDLE instead.
  - HDR:
    - m_axis_tvalid=1; m_axis_tdata = {zeros, 8'hA5, sel zero-extended to 8 bits, seq[sel], o_pkt_cnt}. Bits [63:56]=A5, [55:48]=ch, [47:32]=seq, [31:0]=pkt_cnt.
    - Hold tdata until m_axis_tready=1, then go to DATA with beat counter = 0.
  - DATA:
    - m_axis_tvalid=1; m_axis_tdata = i_ch_data slice of sel (combinational mux).
    - o_ch_rd[sel] = m_axis_tvalid & m_axis_tready; all other bits 0.
    - Beat counter increments per accepted beat.
    - m_axis_tlast=1 when beat counter = BURST_LEN-1.
    - On the accepted tlast beat:
      - seq[sel] += 1, wrapping at 16 bits.
      - o_pkt_cnt += 1, wrapping at 32 bits.
      - Go to ARB if en_d=1, else IDLE.
- Backpressure: while m_axis_tvalid=1 and m_axis_tready=0, tdata, tlast and sel are stable and o_ch_rd=0.
- i_enable drop mid-packet: the current packet completes in full, no truncation. No new grant is made afterwards.
- i_enable 0->1 mid-packet: o_cfg_rst still pulses; the current packet continues unaffected.
- i_ch_rdy is sampled only in ARB. A drop during DATA is ignored; the FIFO guarantees BURST_LEN words at grant.
- o_busy=1 in HDR and DATA.
- Latency: grant to header valid = 1 cycle. Packet length = BURST_LEN+1 accepted beats. Minimum inter-packet gap = 1 cycle (ARB).

Test Plan:
- Reset then enable: rst high 3 cycles; i_enable 0->1 -> o_cfg_rst high exactly 1 cycle, no tvalid in that cycle, all outputs 0 during reset.
- Single requester: i_ch_rdy=4'b0100, tready=1, BURST_LEN=16 -> header 0xA502_0000_0000_0000, then 16 data beats from channel 2, o_ch_rd[2] pulsed 16 times, tlast on beat 17, o_pkt_cnt=1.
- Round-robin: i_ch_rdy=4'b1111 held -> grant order 0,1,2,3,0; second header of channel 0 shows seq=1 and pkt_cnt=4.
- Backpressure: tready toggled 1,0,0,1 during DATA -> tdata/tlast stable while stalled, o_ch_rd=0 on stalled cycles, exactly 16 reads total.
- Disable mid-packet: drop i_enable at data beat 5 -> packet completes with tlast at beat 16, then IDLE with no further grants despite i_ch_rdy=4'b1111.
- Reset mid-packet: assert rst at data beat 8 -> next cycle tvalid=0, o_pkt_cnt=0; after re-enable the first header is channel 0 with seq=0.

Source files
------------

// File: rtl/aurora_tx_sched.sv
// Round-robin scheduler sharing one Aurora TX AXI-stream lane among N_CH FWFT
// channel FIFOs. Each grant emits one header word plus BURST_LEN payload words.
module aurora_tx_sched #(
  parameter int DATA_WD   = 64,
  parameter int N_CH      = 4,
  parameter int CH_WD     = 2,
  parameter int BURST_LEN = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  input  logic [N_CH-1:0]         i_ch_rdy,
  input  logic [N_CH*DATA_WD-1:0] i_ch_data,
  output logic [N_CH-1:0]         o_ch_rd,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WD-1:0]      m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    o_cfg_rst,
  output logic                    o_busy,
  output logic [31:0]             o_pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    HDR  = 2'd2,
    DATA = 2'd3
  } state_e;

  localparam logic [7:0]       LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [CH_WD-1:0] LAST_CH   = CH_WD'(N_CH - 1);

  state_e                       state_q, state_d;
  logic                         en_d_q, en_d_d;
  logic                         cfg_rst_q, cfg_rst_d;
  logic                         tvalid_q, tvalid_d;
  logic                         tlast_q, tlast_d;
  logic                         busy_q, busy_d;
  logic [CH_WD-1:0]             sel_q, sel_d;
  logic [CH_WD-1:0]             last_grant_q, last_grant_d;
  logic [7:0]                   beat_q, beat_d;
  logic [N_CH-1:0][15:0]        seq_q, seq_d;
  logic [31:0]                  pkt_cnt_q, pkt_cnt_d;
  logic [DATA_WD-1:0]           hdr_q, hdr_d;

  logic                         hit_s;
  logic                         found_s;
  logic [CH_WD-1:0]             cand_s;
  logic [CH_WD-1:0]             pick_s;
  logic [N_CH-1:0][DATA_WD-1:0] ch_words_s;

  assign ch_words_s = i_ch_data;

  // Round-robin search starting one past the previous grant.
  always_comb begin
    hit_s   = 1'b0;
    found_s = 1'b0;
    cand_s  = '0;
    pick_s  = '0;
    for (int i = 1; i <= N_CH; i++) begin
      cand_s  = CH_WD'((int'(last_grant_q) + i) % N_CH);
      found_s = !hit_s && i_ch_rdy[cand_s];
      pick_s  = found_s ? cand_s : pick_s;
      hit_s   = hit_s | found_s;
    end
  end

  // Next-state and next-output computation for the packet sequencer.
  always_comb begin
    state_d      = state_q;
    en_d_d       = i_enable;
    cfg_rst_d    = i_enable & ~en_d_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    busy_d       = busy_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    seq_d        = seq_q;
    pkt_cnt_d    = pkt_cnt_q;
    hdr_d        = hdr_q;
    case (state_q)
      IDLE: begin
        if (en_d_q && !cfg_rst_q) begin
          state_d = ARB;
        end else begin
          state_d = IDLE;
        end
      end
      ARB: begin
        // A disable seen here wins over a pending requester: no new grant.
        if (!en_d_q) begin
          state_d = IDLE;
        end else if (hit_s) begin
          state_d      = HDR;
          sel_d        = pick_s;
          last_grant_d = pick_s;
          tvalid_d     = 1'b1;
          tlast_d      = 1'b0;
          busy_d       = 1'b1;
          hdr_d        = '0;
          hdr_d[63:0]  = {8'hA5, 8'(pick_s), seq_q[pick_s], pkt_cnt_q};
        end else begin
          state_d = ARB;
        end
      end
      HDR: begin
        if (m_axis_tready) begin
          state_d = DATA;
          beat_d  = 8'd0;
          tlast_d = (LAST_BEAT == 8'd0);
        end else begin
          state_d = HDR;
        end
      end
      DATA: begin
        if (m_axis_tready && tlast_q) begin
          seq_d[sel_q] = seq_q[sel_q] + 16'd1;
          pkt_cnt_d    = pkt_cnt_q + 32'd1;
          tvalid_d     = 1'b0;
          tlast_d      = 1'b0;
          busy_d       = 1'b0;
          state_d      = en_d_q ? ARB : IDLE;
        end else if (m_axis_tready) begin
          beat_d  = beat_q + 8'd1;
          tlast_d = ((beat_q + 8'd1) == LAST_BEAT);
        end else begin
          state_d = DATA;
        end
      end
      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // Payload is taken straight from the granted FIFO head; pops only on accepted beats.
  always_comb begin
    o_ch_rd      = '0;
    m_axis_tdata = '0;
    if (state_q == DATA) begin
      m_axis_tdata   = ch_words_s[sel_q];
      o_ch_rd[sel_q] = tvalid_q & m_axis_tready;
    end else if (state_q == HDR) begin
      m_axis_tdata = hdr_q;
    end else begin
      m_axis_tdata = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      en_d_q       <= 1'b0;
      cfg_rst_q    <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      busy_q       <= 1'b0;
      sel_q        <= '0;
      last_grant_q <= LAST_CH;
      beat_q       <= 8'd0;
      seq_q        <= '0;
      pkt_cnt_q    <= 32'd0;
      hdr_q        <= '0;
    end else begin
      state_q      <= state_d;
      en_d_q       <= en_d_d;
      cfg_rst_q    <= cfg_rst_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      busy_q       <= busy_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
      seq_q        <= seq_d;
      pkt_cnt_q    <= pkt_cnt_d;
      hdr_q        <= hdr_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign o_cfg_rst     = cfg_rst_q;
  assign o_busy        = busy_q;
  assign o_pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_aurora_tx_sched.sv
// Bench for aurora_tx_sched: directed scenarios then randomized packets, checked
// against a transaction-level model of the arbiter, counters and FIFO heads.
module tb_aurora_tx_sched;

  localparam int DATA_WD   = 64;
  localparam int N_CH      = 4;
  localparam int CH_WD     = 2;
  localparam int BURST_LEN = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    i_enable;
  logic [N_CH-1:0]         i_ch_rdy;
  logic [N_CH*DATA_WD-1:0] i_ch_data;
  logic [N_CH-1:0]         o_ch_rd;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic [DATA_WD-1:0]      m_axis_tdata;
  logic                    m_axis_tlast;
  logic                    o_cfg_rst;
  logic                    o_busy;
  logic [31:0]             o_pkt_cnt;

  always #5 clk = ~clk;

  aurora_tx_sched #(
    .DATA_WD  (DATA_WD),
    .N_CH     (N_CH),
    .CH_WD    (CH_WD),
    .BURST_LEN(BURST_LEN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (i_enable),
    .i_ch_rdy     (i_ch_rdy),
    .i_ch_data    (i_ch_data),
    .o_ch_rd      (o_ch_rd),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .o_cfg_rst    (o_cfg_rst),
    .o_busy       (o_busy),
    .o_pkt_cnt    (o_pkt_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: last grant, per-channel sequence numbers, packet count, FIFO heads.
  logic [CH_WD-1:0]   mdl_last;
  logic [15:0]        mdl_seq [N_CH];
  logic [31:0]        mdl_pkt;
  logic [DATA_WD-1:0] heads   [N_CH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_WD-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  task automatic drive_heads();
    i_ch_data = {heads[3], heads[2], heads[1], heads[0]};
  endtask

  task automatic model_reset();
    mdl_last = CH_WD'(N_CH - 1);
    mdl_pkt  = 32'd0;
    foreach (mdl_seq[k]) mdl_seq[k] = 16'd0;
  endtask

  function automatic logic [CH_WD-1:0] next_grant(input logic [N_CH-1:0] rdy);
    logic [CH_WD-1:0] c;
    for (int k = 1; k <= N_CH; k++) begin
      c = CH_WD'((int'(mdl_last) + k) % N_CH);
      if (rdy[c]) return c;
    end
    return '0;
  endfunction

  function automatic logic [63:0] exp_hdr(input logic [CH_WD-1:0] ch);
    return {8'hA5, 8'(ch), mdl_seq[ch], mdl_pkt};
  endfunction

  // Receives one packet. mode: 0 always ready, 1 ready pattern 1,0,0,1, 2 random.
  // exp_gap: idle cycles expected before the header (-1 = don't care).
  // drop/rise/abort_beat: beat index at which i_enable falls/rises or rst fires.
  task automatic recv_packet(input logic [N_CH-1:0] rdy, input int mode, input int exp_gap,
                             input int drop_beat, input int rise_beat, input int abort_beat,
                             output int reads, output int pulses);
    logic [CH_WD-1:0] ch;
    int  beat, gap, cyc;
    bit  done, pop, aborted, hdr_seen;
    ch = next_grant(rdy);
    i_ch_rdy = rdy;
    beat = 0; gap = 0; cyc = 0; reads = 0; pulses = 0;
    done = 1'b0; aborted = 1'b0; hdr_seen = 1'b0;
    while (!done) begin
      pop = 1'b0;
      case (mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (beat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
        default: m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
      if (mode == 2 && beat > 0) i_ch_rdy = 4'($urandom_range(0, 15));
      if (beat == drop_beat) i_enable = 1'b0;
      if (beat == rise_beat) i_enable = 1'b1;
      if (beat == abort_beat) begin
        rst = 1'b1;
        i_enable = 1'b0;
        aborted = 1'b1;
        done = 1'b1;
      end
      drive_heads();
      #1;
      pulses += int'(o_cfg_rst);
      if (!aborted) begin
        if (m_axis_tvalid !== 1'b1) begin
          if (beat > 0) chk("tvalid_mid_pkt", 64'(m_axis_tvalid), 64'd1);
          else gap++;
          chk("ch_rd_no_valid", 64'(o_ch_rd), 64'd0);
        end else begin
          if (!hdr_seen && exp_gap >= 0) chk("gap", 64'(gap), 64'(exp_gap));
          hdr_seen = 1'b1;
          chk("busy", 64'(o_busy), 64'd1);
          if (beat == 0) chk("hdr", m_axis_tdata, exp_hdr(ch));
          else chk("data", m_axis_tdata, heads[ch]);
          chk("tlast", 64'(m_axis_tlast), 64'(beat == BURST_LEN));
          chk("ch_rd", 64'(o_ch_rd), (beat > 0 && m_axis_tready) ? (64'd1 << ch) : 64'd0);
          reads += int'(o_ch_rd != '0);
          if (m_axis_tready) begin
            if (beat > 0) pop = 1'b1;
            if (beat == BURST_LEN) done = 1'b1;
            beat++;
          end
        end
        cyc++;
        if (cyc > 300) begin
          chk("pkt_timeout", 64'(beat), 64'(BURST_LEN + 1));
          done = 1'b1;
        end
      end
      tick();
      if (pop) heads[ch] = rand_word();
    end
    if (aborted) begin
      rst = 1'b0;
      chk("abort_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("abort_tlast", 64'(m_axis_tlast), 64'd0);
      chk("abort_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
      chk("abort_busy", 64'(o_busy), 64'd0);
      model_reset();
    end else if (beat > BURST_LEN) begin
      mdl_seq[ch] = mdl_seq[ch] + 16'd1;
      mdl_pkt     = mdl_pkt + 32'd1;
      mdl_last    = ch;
      chk("pkt_cnt", 64'(o_pkt_cnt), 64'(mdl_pkt));
      chk("tvalid_after_pkt", 64'(m_axis_tvalid), 64'd0);
    end
  endtask

  initial begin
    int reads, pulses;
    rst = 1'b1; i_enable = 1'b0; i_ch_rdy = '0; m_axis_tready = 1'b0;
    foreach (heads[k]) heads[k] = rand_word();
    drive_heads();
    model_reset();

    // Reset for three cycles: every output quiet.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
      chk("rst_ch_rd", 64'(o_ch_rd), 64'd0);
      chk("rst_cfg_rst", 64'(o_cfg_rst), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
    end
    rst = 1'b0;
    tick();
    tick();
    chk("idle_tvalid", 64'(m_axis_tvalid), 64'd0);

    // Enable edge: exactly one cfg_rst cycle, no traffic.
    i_enable = 1'b1;
    tick();
    chk("cfg_rst_pulse", 64'(o_cfg_rst), 64'd1);
    chk("cfg_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("cfg_rst_clear", 64'(o_cfg_rst), 64'd0);
      chk("no_req_tvalid", 64'(m_axis_tvalid), 64'd0);
    end

    // Single requester on channel 2.
    recv_packet(4'b0100, 0, -1, -1, -1, -1, reads, pulses);
    chk("single_reads", 64'(reads), 64'd16);
    chk("single_pkt_cnt", 64'(o_pkt_cnt), 64'd1);

    // Backpressure on channel 2.
    recv_packet(4'b0100, 1, 1, -1, -1, -1, reads, pulses);
    chk("bp_reads", 64'(reads), 64'd16);

    // Enable falls and rises mid-packet: packet intact, one cfg_rst pulse.
    recv_packet(4'b0011, 0, 1, 3, 6, -1, reads, pulses);
    chk("toggle_pulses", 64'(pulses), 64'd1);
    chk("toggle_reads", 64'(reads), 64'd16);

    // Disable at data beat 5: packet completes, then no more grants.
    recv_packet(4'b1111, 0, 1, 5, -1, -1, reads, pulses);
    chk("disable_reads", 64'(reads), 64'd16);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("disabled_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("disabled_busy", 64'(o_busy), 64'd0);
    end

    // Reset at data beat 8.
    i_enable = 1'b1;
    tick(); tick(); tick();
    recv_packet(4'b1111, 0, -1, -1, -1, 8, reads, pulses);
    tick(); tick();

    // Round-robin after reset: grants 0,1,2,3,0.
    i_enable = 1'b1;
    recv_packet(4'b1111, 0, -1, -1, -1, -1, reads, pulses);
    for (int p = 0; p < 4; p++) recv_packet(4'b1111, 0, 1, -1, -1, -1, reads, pulses);
    chk("rr_pkt_cnt", 64'(o_pkt_cnt), 64'd5);

    // Randomized requesters, ready and payload.
    for (int p = 0; p < 40; p++) begin
      recv_packet(4'($urandom_range(1, 15)), 2, 1, -1, -1, -1, reads, pulses);
      chk("rand_reads", 64'(reads), 64'd16);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
